// File: rtl/otp_digit_emitter_if.sv
// Code/character handshake bundle between the HOTP digit emitter and its driver/consumer.
interface otp_digit_emitter_if #(
  parameter int CODE_WIDTH = 20,
  parameter int DIGITS     = 6
);
  logic                    start;
  logic [CODE_WIDTH-1:0]   code;
  logic [4*DIGITS-1:0]     bcd;
  logic [7:0]              char_data;
  logic                    char_valid;
  logic                    char_ready;
  logic                    busy;
  logic                    done;
  logic                    overflow;

  modport master (
    output start, code, char_ready,
    input  bcd, char_data, char_valid, busy, done, overflow
  );

  modport slave (
    input  start, code, char_ready,
    output bcd, char_data, char_valid, busy, done, overflow
  );
endinterface

// File: rtl/otp_digit_emitter.sv
// Converts a binary HOTP code to decimal digits (double-dabble) and streams them as ASCII, MSD first.
//
//   state   | meaning
//   IDLE    | waiting for start; bcd/overflow hold the last result
//   CONVERT | one add-3/shift iteration per cycle, CODE_WIDTH cycles
//   EMIT    | presenting digit idx as ASCII until accepted; idx 0 ends the run
module otp_digit_emitter #(
  parameter int CODE_WIDTH = 20,
  parameter int DIGITS     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  otp_digit_emitter_if.slave   bus
);

  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(CODE_WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODE_WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d, adj;
  logic [CODE_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= IDX_TOP;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    // Add-3 correction so each nibble stays a valid decimal digit after the shift.
    adj = acc_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          sr_d    = bus.code;
          cnt_d   = '0;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = IDX_TOP;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        acc_d = {adj[ACC_W-2:0], sr_q[CODE_WIDTH-1]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_LAST) begin
          bcd_d   = acc_d[BCD_W-1:0];
          ovf_d   = |acc_d[ACC_W-1:BCD_W];
          idx_d   = IDX_TOP;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.char_ready) begin
          if (idx_q == '0) begin
            idx_d   = IDX_TOP;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bcd        = bcd_q;
  assign bus.overflow   = ovf_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.char_valid = (state_q == EMIT);
  assign bus.char_data  = 8'h30 | {4'h0, bcd_q[4*idx_q +: 4]};

endmodule
